// File: rtl/word_sequencer_1553_pkg.sv
// Shared definitions for the 1553 word sequencer: FIFO entry layout,
// sync tag encodings and the sequencer state type.
package word_seq_1553_pkg;

    localparam int ENTRY_W   = 18;
    localparam int CSW_BIT   = 17;
    localparam int DW_BIT    = 16;
    localparam int DWORD_MSB = 15;

    localparam logic [1:0] TAG_CSW = 2'b10;
    localparam logic [1:0] TAG_DW  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_GAP,
        ST_LAUNCH,
        ST_WAIT_RISE,
        ST_WAIT_FALL
    } seq_state_t;

    // Only the two single-hot tags are sendable; 00 and 11 are rejected.
    function automatic logic tag_legal(input logic [1:0] tag);
        return (tag == TAG_CSW) || (tag == TAG_DW);
    endfunction

endpackage

// File: rtl/sync_fifo_1553.sv
// Synchronous FIFO with first-word fall-through head, used to buffer
// tagged 1553 words ahead of the sequencer.
module sync_fifo_1553 #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A push while full is only taken when the same cycle frees a slot.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign data_out = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/word_sequencer_1553.sv
// Feeds tagged 1553 words from a FIFO to encoder_1553 one at a time,
// honouring the encoder busy handshake and inserting an inter-message gap
// before a command/status word that follows a sent word.
// Optional macro WORD_SEQ_1553_STATS_EN adds saturating words_sent and
// msgs_sent counters.
module word_sequencer_1553
    import word_seq_1553_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int GAP_CYCLES    = 8,
    parameter int START_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [17:0]            wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            tx_dword,
    output logic                   tx_csw,
    output logic                   tx_dw,
    input  logic                   tx_busy,
    output logic                   seq_busy,
    output logic                   err_tag,
    output logic                   err_timeout
`ifdef WORD_SEQ_1553_STATS_EN
    ,
    output logic [15:0]            words_sent,
    output logic [15:0]            msgs_sent
`endif
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);

    seq_state_t           state;
    logic [ENTRY_W-1:0]   head;
    logic [1:0]           head_tag;
    logic                 empty;
    logic                 pop;
    logic                 last_sent;
    logic [GW-1:0]        gap_cnt;
    logic [TW-1:0]        to_cnt;

    assign head_tag = head[CSW_BIT:DW_BIT];

    // The head is consumed on launch, or discarded when its tag is illegal.
    assign pop = (state == ST_LAUNCH) ||
                 ((state == ST_CHECK) && !tag_legal(head_tag));

    sync_fifo_1553 #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .data_in  (wr_data),
        .pop      (pop),
        .data_out (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    // Sequencer FSM with registered strobes, error pulses and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tx_dword    <= '0;
            tx_csw      <= 1'b0;
            tx_dw       <= 1'b0;
            seq_busy    <= 1'b0;
            err_tag     <= 1'b0;
            err_timeout <= 1'b0;
            last_sent   <= 1'b0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
        end else begin
            tx_csw      <= 1'b0;
            tx_dw       <= 1'b0;
            err_tag     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state    <= ST_CHECK;
                        seq_busy <= 1'b1;
                    end else begin
                        last_sent <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (!tag_legal(head_tag)) begin
                        err_tag  <= 1'b1;
                        state    <= ST_IDLE;
                        seq_busy <= 1'b0;
                    end else if ((head_tag == TAG_CSW) && last_sent && (GAP_CYCLES > 0)) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                    end else begin
                        // Strobe is registered on entry so it is high during LAUNCH.
                        state    <= ST_LAUNCH;
                        tx_dword <= head[DWORD_MSB:0];
                        tx_csw   <= head[CSW_BIT];
                        tx_dw    <= head[DW_BIT];
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state    <= ST_LAUNCH;
                        tx_dword <= head[DWORD_MSB:0];
                        tx_csw   <= head[CSW_BIT];
                        tx_dw    <= head[DW_BIT];
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    // The launch cycle itself counts toward the start timeout.
                    last_sent <= 1'b1;
                    to_cnt    <= TW'(1);
                    state     <= ST_WAIT_RISE;
                end
                ST_WAIT_RISE: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_FALL;
                    end else if (to_cnt >= TW'(START_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        last_sent   <= 1'b0;
                        state       <= ST_IDLE;
                        seq_busy    <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_WAIT_FALL: begin
                    if (!tx_busy) begin
                        state    <= ST_IDLE;
                        seq_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    seq_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef WORD_SEQ_1553_STATS_EN
    // Saturating launch counters; observation only, no effect on sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_sent <= '0;
            msgs_sent  <= '0;
        end else if (state == ST_LAUNCH) begin
            if (words_sent != '1) begin
                words_sent <= words_sent + 1'b1;
            end
            if (tx_csw && (msgs_sent != '1)) begin
                msgs_sent <= msgs_sent + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_word_sequencer_1553.sv
// Directed bench for word_sequencer_1553: a per-cycle vector table for the
// basic launch path, then hand-written sequences for gaps, tag errors,
// start timeouts, reset and FIFO overflow against a small encoder model.
module tb_word_sequencer_1553;

    localparam int DEPTH = 16;
    localparam int GAP   = 8;
    localparam int TMO   = 4;

    localparam int M_AUTO   = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STUCK  = 2;
    localparam int M_MANUAL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [17:0] wr_data = '0;
    logic        full;
    logic [4:0]  level;
    logic [15:0] tx_dword;
    logic        tx_csw;
    logic        tx_dw;
    logic        tx_busy = 1'b0;
    logic        seq_busy;
    logic        err_tag;
    logic        err_timeout;
`ifdef WORD_SEQ_1553_STATS_EN
    logic [15:0] words_sent;
    logic [15:0] msgs_sent;
`endif

    word_sequencer_1553 #(
        .DEPTH         (DEPTH),
        .GAP_CYCLES    (GAP),
        .START_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .level       (level),
        .tx_dword    (tx_dword),
        .tx_csw      (tx_csw),
        .tx_dw       (tx_dw),
        .tx_busy     (tx_busy),
        .seq_busy    (seq_busy),
        .err_tag     (err_tag),
        .err_timeout (err_timeout)
`ifdef WORD_SEQ_1553_STATS_EN
        ,
        .words_sent  (words_sent),
        .msgs_sent   (msgs_sent)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Encoder model state
    int   mode = M_MANUAL;
    int   hold = 40;
    int   busy_cnt = 0;
    logic pending = 1'b0;
    logic manual_busy = 1'b0;

    // Encoder model: busy rises the cycle after a strobe and lasts `hold` cycles.
    always @(posedge clk) begin
        #2;
        case (mode)
            M_MANUAL: tx_busy = manual_busy;
            M_NEVER:  tx_busy = 1'b0;
            M_STUCK:  tx_busy = 1'b1;
            default: begin
                if (pending) begin
                    busy_cnt = hold;
                    pending  = 1'b0;
                end else if (busy_cnt > 0) begin
                    busy_cnt = busy_cnt - 1;
                end
                tx_busy = (busy_cnt > 0);
                if (tx_csw || tx_dw) pending = 1'b1;
            end
        endcase
        if (mode != M_AUTO) begin
            pending  = 1'b0;
            busy_cnt = 0;
        end
    end

    typedef struct {
        int          cyc;
        logic        csw;
        logic        dw;
        logic [15:0] dword;
    } launch_t;

    launch_t launches[$];
    int      tag_errs[$];
    int      tmo_errs[$];
    int      both_strobes = 0;

    // Monitor: log every strobe and error pulse with its cycle number.
    always @(negedge clk) begin
        launch_t l;
        if (tx_csw || tx_dw) begin
            l.cyc = cyc;
            l.csw = tx_csw;
            l.dw = tx_dw;
            l.dword = tx_dword;
            launches.push_back(l);
        end
        if (tx_csw && tx_dw) both_strobes++;
        if (err_tag) tag_errs.push_back(cyc);
        if (err_timeout) tmo_errs.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [17:0] pq[$];

    // Push every word in pq on consecutive cycles; p0 is the first push cycle.
    task automatic push_q(output int p0);
        @(posedge clk); #1;
        p0 = cyc;
        for (int i = 0; i < pq.size(); i++) begin
            wr_en = 1'b1;
            wr_data = pq[i];
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((seq_busy || level != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: not idle after %0d cycles, level %0d", name, budget, level);
        end
        repeat (3) @(posedge clk);
    endtask

    typedef struct {
        logic        wr;
        logic [17:0] data;
        logic        busy;
        logic        csw;
        logic        dw;
        logic [15:0] dword;
        logic [4:0]  lvl;
        logic        sb;
        logic        et;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int p;
        logic [31:0] got;
        logic [31:0] exp;

        // Per-cycle vectors: push csw 5555 into an empty FIFO, busy handshake
        // by hand, then a data word 1234 after the sequencer returns to idle.
        tbl[0]  = '{1'b1, 18'h25555, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 18'h00000, 1'b0, 1'b1, 1'b0, 16'h5555, 5'd1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 18'h00000, 1'b1, 1'b0, 1'b0, 16'h5555, 5'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 18'h00000, 1'b1, 1'b0, 1'b0, 16'h5555, 5'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 16'h5555, 5'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 18'h11234, 1'b0, 1'b0, 1'b0, 16'h5555, 5'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 16'h5555, 5'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 16'h5555, 5'd1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b1, 16'h1234, 5'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 16'h1234, 5'd0, 1'b1, 1'b0};

        // Power-on reset state
        mode = M_MANUAL;
        manual_busy = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("por_outputs",
              {8'h0, full, level, tx_dword, tx_csw, tx_dw, seq_busy, err_tag, err_timeout},
              32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            wr_en = tbl[i].wr;
            wr_data = tbl[i].data;
            manual_busy = tbl[i].busy;
            @(negedge clk);
            got = {7'h0, tx_csw, tx_dw, tx_dword, level, seq_busy, err_tag};
            exp = {7'h0, tbl[i].csw, tbl[i].dw, tbl[i].dword, tbl[i].lvl, tbl[i].sb, tbl[i].et};
            check($sformatf("vec%0d", i), got, exp);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;

        // Reset while three entries are queued behind a stuck word
        mode = M_STUCK;
        do_reset();
        pq = '{18'h20001, 18'h10002, 18'h10003, 18'h10004};
        push_q(p);
        repeat (8) @(negedge clk);
        check("pre_reset_level", 32'(level), 32'd3);
        do_reset();
        mode = M_AUTO;
        hold = 40;
        @(negedge clk);
        check("reset_outputs",
              {8'h0, full, level, tx_dword, tx_csw, tx_dw, seq_busy, err_tag, err_timeout},
              32'h0);

        // Single csw into an empty FIFO: strobe 3 cycles after the push
        repeat (3) @(posedge clk);
        launches.delete();
        pq = '{18'h25555};
        push_q(p);
        wait_idle("single_csw", 200);
        check("single_count", 32'(launches.size()), 32'd1);
        check("single_latency", 32'(launches[0].cyc - p), 32'd3);
        check("single_word", {14'h0, launches[0].csw, launches[0].dw, launches[0].dword},
              {14'h0, 2'b10, 16'h5555});

        // csw, dw, csw: data word not gapped, second csw gapped
        launches.delete();
        pq = '{18'h2ABCD, 18'h11234, 18'h25678};
        push_q(p);
        wait_idle("msg_gap", 400);
        check("gap_count", 32'(launches.size()), 32'd3);
        check("gap_first_latency", 32'(launches[0].cyc - p), 32'd3);
        check("gap_dw_spacing", 32'(launches[1].cyc - launches[0].cyc), 32'd44);
        check("gap_dw_word", {14'h0, launches[1].csw, launches[1].dw, launches[1].dword},
              {14'h0, 2'b01, 16'h1234});
        check("gap_csw_spacing", 32'(launches[2].cyc - launches[1].cyc), 32'(41 + 3 + GAP));
        check("gap_csw_word", {14'h0, launches[2].csw, launches[2].dw, launches[2].dword},
              {14'h0, 2'b10, 16'h5678});

        // Illegal tag is discarded with an error pulse
        launches.delete();
        tag_errs.delete();
        pq = '{18'h3FFFF, 18'h1AAAA};
        push_q(p);
        wait_idle("bad_tag", 200);
        check("tag_err_count", 32'(tag_errs.size()), 32'd1);
        check("tag_err_cycle", 32'(tag_errs[0] - p), 32'd3);
        check("tag_launch_count", 32'(launches.size()), 32'd1);
        check("tag_launch_cycle", 32'(launches[0].cyc - p), 32'd5);
        check("tag_launch_word", {14'h0, launches[0].csw, launches[0].dw, launches[0].dword},
              {14'h0, 2'b01, 16'hAAAA});

        // Encoder never answers: timeout, then the next csw goes without a gap
        mode = M_NEVER;
        launches.delete();
        tmo_errs.delete();
        pq = '{18'h21111, 18'h22222};
        push_q(p);
        wait_idle("timeout", 200);
        check("tmo_launch_count", 32'(launches.size()), 32'd2);
        check("tmo_err_count", 32'(tmo_errs.size()), 32'd2);
        check("tmo_err_cycle", 32'(tmo_errs[0] - launches[0].cyc), 32'(TMO));
        check("tmo_next_launch", 32'(launches[1].cyc - launches[0].cyc), 32'(TMO + 2));
        check("tmo_next_word", {14'h0, launches[1].csw, launches[1].dw, launches[1].dword},
              {14'h0, 2'b10, 16'h2222});

        // Overflow: blocker word holds the sequencer while DEPTH+2 are pushed
        mode = M_STUCK;
        pq = '{18'h10BAD};
        push_q(p);
        repeat (6) @(negedge clk);
        launches.delete();
        pq.delete();
        for (int i = 0; i < DEPTH + 2; i++) pq.push_back(18'h11000 + 18'(i));
        push_q(p);
        @(negedge clk);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_level", 32'(level), 32'(DEPTH));
        mode = M_AUTO;
        hold = 2;
        wait_idle("overflow_drain", 600);
        check("ovf_sent_count", 32'(launches.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            if (i < launches.size()) begin
                check($sformatf("ovf_order%0d", i),
                      {14'h0, launches[i].csw, launches[i].dw, launches[i].dword},
                      {14'h0, 2'b01, 16'h1000 + 16'(i)});
            end
        end

        check("no_dual_strobe", 32'(both_strobes), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
